dir_cmd_conditioner: RTL and testbench
======================================

# dir_cmd_conditioner

Front-end input stage for the segment-game FSM. It conditions four raw push-buttons (right, left, up, down) into a single registered direction command stream: a direction code plus a one-cycle valid strobe. Each button passes through synchronization and counter-based debounce, then press detection, fixed-priority arbitration, and hold-to-repeat. The downstream game FSM consumes `dir`/`dir_valid` directly on the system clock, so no per-button one-pulse logic is needed there.

## Interface
- `DEBOUNCE_CYCLES`, default 1_000_000: consecutive disagreeing cycles before a debounced level flips (10 ms at 100 MHz); must be ≥1.
- `REPEAT_EN`, default 1: 1 enables auto-repeat while held; 0 makes every press a single strobe.
- `REPEAT_DELAY`, default 50_000_000: cycles from the initial strobe to the first repeat strobe; must be ≥2.
- `REPEAT_PERIOD`, default 20_000_000: cycles between subsequent repeat strobes; must be ≥2.
- `CNT_W`, default 27: width of the debounce and repeat counters; must hold every count parameter.
- `clk`  in  1  system clock; the only clock.
- `rst`  in  1  reset, synchronous, active-high.
- `right`, `left`, `up`, `down`  in  1 each  raw asynchronous buttons, active-high.
- `en`  in  1  command acceptance enable from the downstream FSM.
- `dir`  out  2  direction code: RIGHT=0, LEFT=1, UP=2, DOWN=3.
- `dir_valid`  out  1  one-cycle strobe; `dir` is meaningful only while it is high.
- `held`  out  4  debounced levels {down, up, left, right}.

## Operation
- **Synchronizer:** 2-flop synchronizer per button.
- **Debounce:** per-button counter increments while the synchronized value ≠ the debounced level and clears when they agree. On the cycle the count reaches `DEBOUNCE_CYCLES`, the level flips and the counter clears.
- **Press event:** rising edge of a debounced level, detected against its previous-cycle value.
- **Arbitration:** when several press events occur in one cycle, priority is right > left > up > down. Losing events are dropped; they never fire later.
- **Repeat FSM** states IDLE, DELAY, REPEAT; it tracks the active button `act` and a repeat counter.
  - IDLE: on an accepted press of X, strobe X, set `act`=X, go to DELAY, clear the counter.
  - DELAY: when the counter reaches `REPEAT_DELAY`-1, strobe `act`, go to REPEAT, clear the counter.
  - REPEAT: every `REPEAT_PERIOD` cycles, strobe `act`.
  - DELAY or REPEAT, button `act` debounced low: go to IDLE with no strobe.
  - DELAY or REPEAT, a press event of any button (arbitrated): treat as a fresh IDLE press. Strobe it, set `act` to it, go to DELAY, clear the counter.
  - Release of `act` and press of Y in the same cycle: the press wins.
  - `REPEAT_EN`=0: DELAY and REPEAT are never entered. The FSM stays in IDLE and strobes once per press.
- **`en` low:**
  - `dir_valid` is forced to 0 and the FSM is forced to IDLE.
  - Press events are dropped, not queued.
  - Synchronizers, debounce and `held` keep running.
  - A button still held when `en` rises produces no strobe until it is released and pressed again.

## Timing
- **Registered outputs:** `dir`, `dir_valid` and `held` are registered.
- **Reset values:** `dir`=0, `dir_valid`=0, `held`=0. All synchronizer flops, debounce levels and counters are 0; FSM=IDLE; `act`=0.
- **Press latency:** raw input goes high and stays clean, first sampled at edge 1.
  - Synchronizer output is high after edge 2.
  - Debounced level is high after edge 2+`DEBOUNCE_CYCLES`.
  - `dir_valid` is high for exactly one cycle after edge 3+`DEBOUNCE_CYCLES`.
- **Repeat timing:** initial strobe at cycle t. Repeats at t+`REPEAT_DELAY`, then every `REPEAT_PERIOD` cycles after that.
- **Release latency:** `held` bit falls 2+`DEBOUNCE_CYCLES` edges after a clean release. The FSM leaves DELAY/REPEAT on that same edge's next evaluation; no strobe is issued on that cycle.
- **Glitches:** a glitch shorter than `DEBOUNCE_CYCLES` cycles produces no level change.
- **Reset mid-hold:** all state clears. A button still held after `rst` falls is re-debounced and yields a fresh press strobe at the normal latency.
- **Counter saturation:** counters never wrap, because they clear on reaching their terminal values.

## Structure
- **Shared package** (consumed by the game FSM):
  - Direction codes DIR_RIGHT..DIR_DOWN.
  - Repeat FSM state encoding.
- **Sub-module:** `debounce_filter`, a per-button synchronizer plus counter debounce with a `DEBOUNCE_CYCLES` parameter, instantiated four times.
- **Top level:** arbitration, repeat FSM and output registers.

## Test plan
1. `DEBOUNCE_CYCLES`=4, `REPEAT_EN`=0, `en`=1. Raise `up` clean at edge 1 → single `dir_valid` after edge 7 with `dir`=2; `held`=4'b0100.
2. Pulse `left` high for 3 cycles, then low → no `dir_valid`, `held` stays 0. Then hold `left` 5+ cycles → one strobe with `dir`=1.
3. Assert `right` and `down` on the same edge → exactly one strobe with `dir`=0. Releasing `right` while `down` stays held produces no `down` strobe.
4. `REPEAT_EN`=1, `REPEAT_DELAY`=10, `REPEAT_PERIOD`=4. Hold `down` → strobes at t, t+10, t+14, t+18. Releasing `down` stops strobes, FSM returns to IDLE.
5. Hold `up` into REPEAT, then press `left` → immediate `dir`=1 strobe, next strobe 10 cycles later with `dir`=1. No further `up` strobes.
6. Hold `right` with `en`=0 → no strobe. Raise `en` → still none. Assert `rst` for 1 cycle while `right` is held → all outputs 0, then a `dir`=0 strobe 7 edges after `rst` falls (`DEBOUNCE_CYCLES`=4).

Source files
------------

// File: rtl/dir_cmd_conditioner_pkg.sv
// Shared definitions for the direction command path.
// Direction codes are consumed by the downstream game FSM. The repeat-FSM state
// encoding is kept here so that the game FSM and the conditioner agree on it.
package dir_cmd_conditioner_pkg;

  typedef enum logic [1:0] {
    DIR_RIGHT = 2'd0,
    DIR_LEFT  = 2'd1,
    DIR_UP    = 2'd2,
    DIR_DOWN  = 2'd3
  } dir_e;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_DELAY  = 2'd1,
    ST_REPEAT = 2'd2
  } rpt_state_e;

  // Fixed-priority pick among simultaneous press events, bit order {down,up,left,right}.
  // Right has the highest priority and down the lowest. The result is only meaningful when ev != 0.
  function automatic dir_e pick_dir(input logic [3:0] ev);
    dir_e d;
    if (ev[0])      d = DIR_RIGHT;
    else if (ev[1]) d = DIR_LEFT;
    else if (ev[2]) d = DIR_UP;
    else            d = DIR_DOWN;
    return d;
  endfunction

endpackage

// File: rtl/dir_cmd_conditioner_debounce_filter.sv
// debounce_filter: 2-flop synchronizer followed by a counter debounce for one button.
// Ports:
//   clk   - system clock
//   rst   - synchronous active-high reset
//   raw   - raw asynchronous button, active-high
//   level - debounced level (registered)
// The level flips only after the synchronized input has disagreed with it
// for DEBOUNCE_CYCLES consecutive cycles.
module debounce_filter
  import dir_cmd_conditioner_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = 1_000_000,
  parameter int unsigned CNT_W           = 27
) (
  input  logic clk,
  input  logic rst,
  input  logic raw,
  output logic level
);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic             sync0;
  logic             sync1;
  logic [CNT_W-1:0] cnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      sync0 <= 1'b0;
      sync1 <= 1'b0;
      cnt   <= '0;
      level <= 1'b0;
    end else begin
      sync0 <= raw;
      sync1 <= sync0;
      if (sync1 != level) begin
        // The count advancing to DEBOUNCE_CYCLES is the flip point. The counter
        // clears there instead of storing the terminal value.
        if (cnt == CNT_LAST) begin
          level <= sync1;
          cnt   <= '0;
        end else begin
          cnt <= cnt + CNT_W'(1);
        end
      end else begin
        cnt <= '0;
      end
    end
  end

endmodule

// File: rtl/dir_cmd_conditioner.sv
// dir_cmd_conditioner: converts four raw push-buttons into a direction command stream.
// Ports:
//   clk       - system clock (only clock)
//   rst       - synchronous active-high reset
//   right/left/up/down - raw asynchronous buttons, active-high
//   en        - command acceptance enable from the downstream FSM
//   dir       - direction code (RIGHT=0, LEFT=1, UP=2, DOWN=3), valid with dir_valid
//   dir_valid - one-cycle command strobe
//   held      - debounced levels {down, up, left, right}
// Processing chain: debounce per button, press-edge detection, fixed-priority
// arbitration (right > left > up > down), and a hold-to-repeat FSM.
module dir_cmd_conditioner
  import dir_cmd_conditioner_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = 1_000_000,
  parameter bit          REPEAT_EN       = 1'b1,
  parameter int unsigned REPEAT_DELAY    = 50_000_000,
  parameter int unsigned REPEAT_PERIOD   = 20_000_000,
  parameter int unsigned CNT_W           = 27
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       right,
  input  logic       left,
  input  logic       up,
  input  logic       down,
  input  logic       en,
  output logic [1:0] dir,
  output logic       dir_valid,
  output logic [3:0] held
);

  localparam logic [CNT_W-1:0] DELAY_LAST  = CNT_W'(REPEAT_DELAY - 1);
  localparam logic [CNT_W-1:0] PERIOD_LAST = CNT_W'(REPEAT_PERIOD - 1);

  logic [3:0] raw;
  logic [3:0] lvl;
  logic [3:0] lvl_q;
  logic [3:0] rise;
  logic       press_any;
  dir_e       press_dir;

  assign raw = {down, up, left, right};

  for (genvar i = 0; i < 4; i++) begin : g_btn
    debounce_filter #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
      .CNT_W          (CNT_W)
    ) u_debounce (
      .clk  (clk),
      .rst  (rst),
      .raw  (raw[i]),
      .level(lvl[i])
    );
  end

  // The debounce levels are flops already, so held is a registered output.
  assign held = lvl;

  // Edge detection runs even while en is low. A button held across the rising
  // edge of en therefore shows no new press.
  assign rise      = lvl & ~lvl_q;
  assign press_any = |rise;
  assign press_dir = pick_dir(rise);

  rpt_state_e       state, state_n;
  dir_e             act, act_n;
  logic [CNT_W-1:0] rcnt, rcnt_n;
  logic [1:0]       dir_n;
  logic             valid_n;
  logic             act_held;

  assign act_held = lvl[act];

  always_ff @(posedge clk) begin
    if (rst) begin
      lvl_q     <= '0;
      state     <= ST_IDLE;
      act       <= DIR_RIGHT;
      rcnt      <= '0;
      dir       <= '0;
      dir_valid <= 1'b0;
    end else begin
      lvl_q     <= lvl;
      state     <= state_n;
      act       <= act_n;
      rcnt      <= rcnt_n;
      dir       <= dir_n;
      dir_valid <= valid_n;
    end
  end

  always_comb begin
    state_n = state;
    act_n   = act;
    rcnt_n  = rcnt;
    dir_n   = dir;
    valid_n = 1'b0;

    if (!en) begin
      state_n = ST_IDLE;
    end else if (press_any) begin
      // A fresh press restarts the cycle from any state. It takes precedence over
      // a simultaneous release of act and over a repeat that is due on this cycle.
      valid_n = 1'b1;
      dir_n   = press_dir;
      act_n   = press_dir;
      rcnt_n  = '0;
      state_n = REPEAT_EN ? ST_DELAY : ST_IDLE;
    end else begin
      unique case (state)
        ST_DELAY: begin
          if (!act_held) begin
            state_n = ST_IDLE;
          end else if (rcnt == DELAY_LAST) begin
            valid_n = 1'b1;
            dir_n   = act;
            rcnt_n  = '0;
            state_n = ST_REPEAT;
          end else begin
            rcnt_n = rcnt + CNT_W'(1);
          end
        end
        ST_REPEAT: begin
          if (!act_held) begin
            state_n = ST_IDLE;
          end else if (rcnt == PERIOD_LAST) begin
            valid_n = 1'b1;
            dir_n   = act;
            rcnt_n  = '0;
          end else begin
            rcnt_n = rcnt + CNT_W'(1);
          end
        end
        default: begin
          state_n = ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_dir_cmd_conditioner.sv
// Bench for dir_cmd_conditioner. Instance a has repeat disabled and instance b
// has repeat enabled. Both instances use DEBOUNCE_CYCLES=4. Expected strobes are
// queued as (cycle, dir) pairs when the stimulus is applied. A background
// monitor pops an entry and compares it on every dir_valid.
module tb_dir_cmd_conditioner;

  localparam int unsigned DB = 4;

  typedef struct {
    int unsigned cyc;
    logic [1:0]  dir;
  } exp_t;

  logic clk = 1'b0;
  int unsigned cyc = 0;

  logic rst_a = 1'b1, right_a = 1'b0, left_a = 1'b0, up_a = 1'b0, down_a = 1'b0, en_a = 1'b1;
  logic rst_b = 1'b1, right_b = 1'b0, left_b = 1'b0, up_b = 1'b0, down_b = 1'b0, en_b = 1'b1;
  logic [1:0] dir_a, dir_b;
  logic       dir_valid_a, dir_valid_b;
  logic [3:0] held_a, held_b;

  exp_t qa[$];
  exp_t qb[$];
  int compared = 0;
  int failed   = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  dir_cmd_conditioner #(
    .DEBOUNCE_CYCLES(DB), .REPEAT_EN(1'b0), .REPEAT_DELAY(10), .REPEAT_PERIOD(4), .CNT_W(8)
  ) dut_a (
    .clk(clk), .rst(rst_a), .right(right_a), .left(left_a), .up(up_a), .down(down_a),
    .en(en_a), .dir(dir_a), .dir_valid(dir_valid_a), .held(held_a)
  );

  dir_cmd_conditioner #(
    .DEBOUNCE_CYCLES(DB), .REPEAT_EN(1'b1), .REPEAT_DELAY(10), .REPEAT_PERIOD(4), .CNT_W(8)
  ) dut_b (
    .clk(clk), .rst(rst_b), .right(right_b), .left(left_b), .up(up_b), .down(down_b),
    .en(en_b), .dir(dir_b), .dir_valid(dir_valid_b), .held(held_b)
  );

  // Scoreboard consumer. It samples on the falling edge, away from the active edge.
  task automatic monitor();
    exp_t e;
    forever begin
      @(negedge clk);
      if (dir_valid_a !== 1'b0) begin
        compared++;
        if (qa.size() == 0) begin
          failed++;
          $display("FAIL strobe_a: got unexpected dir_valid=%b dir=%0d at cycle %0d, required none",
                   dir_valid_a, dir_a, cyc);
        end else begin
          e = qa.pop_front();
          if (cyc !== e.cyc || dir_a !== e.dir) begin
            failed++;
            $display("FAIL strobe_a: got dir=%0d at cycle %0d, required dir=%0d at cycle %0d",
                     dir_a, cyc, e.dir, e.cyc);
          end
        end
      end
      if (dir_valid_b !== 1'b0) begin
        compared++;
        if (qb.size() == 0) begin
          failed++;
          $display("FAIL strobe_b: got unexpected dir_valid=%b dir=%0d at cycle %0d, required none",
                   dir_valid_b, dir_b, cyc);
        end else begin
          e = qb.pop_front();
          if (cyc !== e.cyc || dir_b !== e.dir) begin
            failed++;
            $display("FAIL strobe_b: got dir=%0d at cycle %0d, required dir=%0d at cycle %0d",
                     dir_b, cyc, e.dir, e.cyc);
          end
        end
      end
    end
  endtask

  task automatic test_reset();
    repeat (3) @(negedge clk);
    compared++;
    if ({dir_a, dir_valid_a, held_a} !== 7'b0) begin
      failed++;
      $display("FAIL reset_a: got dir=%0d valid=%b held=%b, required 0/0/0000", dir_a, dir_valid_a, held_a);
    end
    compared++;
    if ({dir_b, dir_valid_b, held_b} !== 7'b0) begin
      failed++;
      $display("FAIL reset_b: got dir=%0d valid=%b held=%b, required 0/0/0000", dir_b, dir_valid_b, held_b);
    end
    rst_a = 1'b0;
    rst_b = 1'b0;
    repeat (3) @(negedge clk);
  endtask

  task automatic test_single_press();
    int unsigned c;
    @(negedge clk);
    c = cyc;
    up_a = 1'b1;
    qa.push_back('{cyc: c + 3 + DB, dir: 2'd2});
    repeat (12) @(negedge clk);
    compared++;
    if (held_a !== 4'b0100) begin
      failed++;
      $display("FAIL single_held: got %b, required 0100", held_a);
    end
    up_a = 1'b0;
    repeat (12) @(negedge clk);
    compared++;
    if (qa.size() != 0 || held_a !== 4'b0000) begin
      failed++;
      $display("FAIL single_done: got pending=%0d held=%b, required 0/0000", qa.size(), held_a);
    end
    qa.delete();
  endtask

  task automatic test_glitch();
    int unsigned c;
    @(negedge clk);
    left_a = 1'b1;
    repeat (3) @(negedge clk);
    left_a = 1'b0;
    repeat (12) @(negedge clk);
    compared++;
    if (held_a !== 4'b0000) begin
      failed++;
      $display("FAIL glitch_held: got %b, required 0000", held_a);
    end
    c = cyc;
    left_a = 1'b1;
    qa.push_back('{cyc: c + 3 + DB, dir: 2'd1});
    repeat (12) @(negedge clk);
    compared++;
    if (held_a !== 4'b0010) begin
      failed++;
      $display("FAIL glitch_hold_held: got %b, required 0010", held_a);
    end
    left_a = 1'b0;
    repeat (12) @(negedge clk);
    compared++;
    if (qa.size() != 0) begin
      failed++;
      $display("FAIL glitch_pending: got %0d, required 0", qa.size());
    end
    qa.delete();
  endtask

  task automatic test_priority();
    int unsigned c;
    @(negedge clk);
    c = cyc;
    right_a = 1'b1;
    down_a  = 1'b1;
    qa.push_back('{cyc: c + 3 + DB, dir: 2'd0});
    repeat (12) @(negedge clk);
    compared++;
    if (held_a !== 4'b1001) begin
      failed++;
      $display("FAIL prio_held: got %b, required 1001", held_a);
    end
    right_a = 1'b0;
    repeat (15) @(negedge clk);
    compared++;
    if (held_a !== 4'b1000) begin
      failed++;
      $display("FAIL prio_release_held: got %b, required 1000", held_a);
    end
    down_a = 1'b0;
    repeat (12) @(negedge clk);
    compared++;
    if (qa.size() != 0) begin
      failed++;
      $display("FAIL prio_pending: got %0d, required 0", qa.size());
    end
    qa.delete();
  endtask

  task automatic test_repeat();
    int unsigned c, t;
    @(negedge clk);
    c = cyc;
    t = c + 3 + DB;
    down_b = 1'b1;
    qb.push_back('{cyc: t,      dir: 2'd3});
    qb.push_back('{cyc: t + 10, dir: 2'd3});
    qb.push_back('{cyc: t + 14, dir: 2'd3});
    qb.push_back('{cyc: t + 18, dir: 2'd3});
    // The level falls 6 edges after release at t+19. The FSM returns to IDLE
    // before the t+22 repeat would have fired.
    while (cyc < t + 13) @(negedge clk);
    down_b = 1'b0;
    repeat (30) @(negedge clk);
    compared++;
    if (qb.size() != 0 || held_b !== 4'b0000) begin
      failed++;
      $display("FAIL repeat_done: got pending=%0d held=%b, required 0/0000", qb.size(), held_b);
    end
    qb.delete();
  endtask

  task automatic test_preempt();
    int unsigned c, t;
    @(negedge clk);
    c = cyc;
    t = c + 3 + DB;
    up_b = 1'b1;
    qb.push_back('{cyc: t,      dir: 2'd2});
    qb.push_back('{cyc: t + 10, dir: 2'd2});
    qb.push_back('{cyc: t + 14, dir: 2'd2});
    // The left press lands at t+18, on the same cycle that an up repeat is due. The press wins.
    qb.push_back('{cyc: t + 18, dir: 2'd1});
    qb.push_back('{cyc: t + 28, dir: 2'd1});
    while (cyc < t + 11) @(negedge clk);
    left_b = 1'b1;
    while (cyc < t + 23) @(negedge clk);
    left_b = 1'b0;
    up_b   = 1'b0;
    repeat (30) @(negedge clk);
    compared++;
    if (qb.size() != 0) begin
      failed++;
      $display("FAIL preempt_pending: got %0d, required 0", qb.size());
    end
    qb.delete();
  endtask

  task automatic test_enable_reset();
    int unsigned c;
    @(negedge clk);
    en_a    = 1'b0;
    right_a = 1'b1;
    repeat (15) @(negedge clk);
    en_a = 1'b1;
    repeat (15) @(negedge clk);
    compared++;
    if (held_a !== 4'b0001) begin
      failed++;
      $display("FAIL en_held: got %b, required 0001", held_a);
    end
    rst_a = 1'b1;
    @(negedge clk);
    compared++;
    if ({dir_a, dir_valid_a, held_a} !== 7'b0) begin
      failed++;
      $display("FAIL midhold_reset: got dir=%0d valid=%b held=%b, required 0/0/0000",
               dir_a, dir_valid_a, held_a);
    end
    c = cyc;
    rst_a = 1'b0;
    qa.push_back('{cyc: c + 3 + DB, dir: 2'd0});
    repeat (12) @(negedge clk);
    right_a = 1'b0;
    repeat (12) @(negedge clk);
    compared++;
    if (qa.size() != 0) begin
      failed++;
      $display("FAIL en_reset_pending: got %0d, required 0", qa.size());
    end
    qa.delete();
  endtask

  initial begin
    fork
      monitor();
    join_none
    test_reset();
    test_single_press();
    test_glitch();
    test_priority();
    test_repeat();
    test_preempt();
    test_enable_reset();
    repeat (2) @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, failed);
    $finish;
  end

endmodule
